// File: rtl/fft_frame_sequencer_if.sv
// Handshake and frame bus between the FFT frame sequencer and its neighbours.
// master = sequencer side, slave = source / butterfly engine / sink side.
interface fft_frame_sequencer_if #(
    parameter int N  = 3,
    parameter int DW = 32,
    parameter int SW = 2
);
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [DW-1:0]           in_data;
    logic [(1<<N)*DW-1:0]    frame_q;
    logic                    stage_start;
    logic [SW-1:0]           stage_idx;
    logic                    stage_done;
    logic [(1<<N)*DW-1:0]    eng_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [DW-1:0]           out_data;
    logic                    out_last;
    logic                    busy;
    logic                    err;

    modport master (
        input  flush, in_valid, in_data, stage_done, eng_data, out_ready,
        output in_ready, frame_q, stage_start, stage_idx, out_valid, out_data,
               out_last, busy, err
    );

    modport slave (
        output flush, in_valid, in_data, stage_done, eng_data, out_ready,
        input  in_ready, frame_q, stage_start, stage_idx, out_valid, out_data,
               out_last, busy, err
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Loads a frame in bit-reversed order, steps the butterfly engine through N stages, drains in natural order.
// Latency: first output 2N+1 cycles after last input accept (single-cycle engine); stalls on out_ready=0 and on stage_done.
module fft_frame_sequencer #(
    parameter int N  = 3,
    parameter int DW = 32,
    parameter int SW = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    fft_frame_sequencer_if.master bus
);
    localparam int P = 1 << N;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic            err_q, err_d;
    logic            en_q;
    logic [DW-1:0]   buf_q [P];

    logic            in_acc;
    logic            out_acc;
    logic            eng_acc;

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] i);
        logic [N-1:0] r;
        r = '0;
        for (int b = 0; b < N; b++) begin
            r[b] = i[N-1-b];
        end
        return r;
    endfunction

    // Flush discards any handshake landing in the same cycle.
    assign in_acc  = (state_q == ST_LOAD) && en_q && bus.in_valid && !bus.flush;
    assign out_acc = (state_q == ST_DRAIN) && bus.out_ready && !bus.flush;
    assign eng_acc = (state_q == ST_WAIT) && bus.stage_done && !bus.flush;

    // en_q keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            stage_q <= '0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            err_q   <= err_d;
            en_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        err_d   = err_q | (bus.stage_done && (state_q != ST_WAIT));
        if (bus.flush) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            stage_d = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (in_acc) begin
                        cnt_d = cnt_q + 1'b1;
                        if (&cnt_q) begin
                            state_d = ST_RUN;
                            stage_d = '0;
                        end
                    end
                end
                ST_RUN: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_acc) begin
                        if (stage_q == SW'(N-1)) begin
                            state_d = ST_DRAIN;
                            cnt_d   = '0;
                        end else begin
                            stage_d = stage_q + 1'b1;
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_acc) begin
                        cnt_d = cnt_q + 1'b1;
                        if (&cnt_q) begin
                            state_d = ST_LOAD;
                            cnt_d   = '0;
                            stage_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    always_comb begin
        bus.in_ready    = (state_q == ST_LOAD) && en_q;
        bus.stage_start = (state_q == ST_RUN);
        bus.stage_idx   = stage_q;
        bus.out_valid   = (state_q == ST_DRAIN);
        bus.out_data    = buf_q[cnt_q];
        bus.out_last    = (state_q == ST_DRAIN) && (&cnt_q);
        bus.busy        = (state_q != ST_LOAD);
        bus.err         = err_q;
        bus.frame_q     = '0;
        for (int k = 0; k < P; k++) begin
            bus.frame_q[k*DW +: DW] = buf_q[k];
        end
    end

    // Engine results replace the whole frame; inputs land at their bit-reversed slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < P; k++) begin
                buf_q[k] <= '0;
            end
        end else if (eng_acc) begin
            for (int k = 0; k < P; k++) begin
                buf_q[k] <= bus.eng_data[k*DW +: DW];
            end
        end else if (in_acc) begin
            buf_q[bitrev(cnt_q)] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with a behavioural butterfly engine and output monitor.
module tb_fft_frame_sequencer;
    localparam int N  = 3;
    localparam int DW = 32;
    localparam int SW = 2;
    localparam int P  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_frame_sequencer_if #(.N(N), .DW(DW), .SW(SW)) bus ();
    fft_frame_sequencer #(.N(N), .DW(DW), .SW(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic            flush, in_valid, out_ready, eng_done, spur_done;
    logic [DW-1:0]   in_data;
    logic [P*DW-1:0] eng_dat, spur_dat;

    assign bus.flush      = flush;
    assign bus.in_valid   = in_valid;
    assign bus.in_data    = in_data;
    assign bus.out_ready  = out_ready;
    assign bus.stage_done = eng_done | spur_done;
    assign bus.eng_data   = spur_done ? spur_dat : eng_dat;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [P*DW-1:0] got, input logic [P*DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] br(input int k);
        logic [2:0] v;
        v = 3'(k);
        return {v[0], v[1], v[2]};
    endfunction

    // Monitor: samples on the falling edge; handshakes complete on the following rising edge.
    int            cyc = 0;
    int            last_in_cyc = 0;
    int            first_out_cyc = 0;
    int            dbl_start = 0;
    logic          prev_ov = 1'b0;
    logic          prev_st = 1'b0;
    logic [DW-1:0] oq [$];
    logic          ol [$];
    int            sq [$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready && !flush) last_in_cyc <= cyc;
            if (bus.out_valid && !prev_ov) first_out_cyc <= cyc;
            if (bus.out_valid && bus.out_ready && !flush) begin
                oq.push_back(bus.out_data);
                ol.push_back(bus.out_last);
            end
            if (bus.stage_start) begin
                sq.push_back(int'(bus.stage_idx));
                if (prev_st) dbl_start <= dbl_start + 1;
            end
        end
        prev_ov <= bus.out_valid;
        prev_st <= bus.stage_start;
    end

    // Butterfly engine model: adds eng_delta to every slot, done eng_delay cycles after the cycle following start.
    int            eng_delay = 0;
    logic [DW-1:0] eng_delta = '0;
    int            kill_gen  = 0;

    initial begin
        int g;
        eng_done = 1'b0;
        eng_dat  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.stage_start) begin
                g = kill_gen;
                @(posedge clk);
                repeat (eng_delay) @(posedge clk);
                #1;
                if (g == kill_gen && rst_n) begin
                    for (int k = 0; k < P; k++) begin
                        eng_dat[k*DW +: DW] = bus.frame_q[k*DW +: DW] + eng_delta;
                    end
                    eng_done = 1'b1;
                    @(posedge clk);
                    #1;
                    eng_done = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] base, input int cnt, input bit gaps);
        for (int i = 0; i < cnt; i++) begin
            int t;
            t = 0;
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = base + DW'(i);
            do begin
                @(negedge clk);
                t++;
            end while (!bus.in_ready && t < 200);
            if (t >= 200) check("in_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n);
        int t;
        t = 0;
        while (oq.size() < n && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (oq.size() < n) check("out_timeout", oq.size(), n);
        #1;
    endtask

    task automatic check_frame(input string tag, input logic [DW-1:0] base, input logic [DW-1:0] add);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_count"}, oq.size(), P);
        for (int k = 0; k < P; k++) begin
            if (k < oq.size()) begin
                check($sformatf("%s_data%0d", tag, k), oq[k], base + DW'(br(k)) + add);
                check($sformatf("%s_last%0d", tag, k), ol[k], (k == P-1));
            end
        end
        oq.delete();
        ol.delete();
    endtask

    task automatic check_starts(input string tag);
        check({tag, "_nstart"}, sq.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < sq.size()) check($sformatf("%s_idx%0d", tag, k), sq[k], k);
        end
        check({tag, "_dbl"}, dbl_start, 0);
        sq.delete();
    endtask

    initial begin
        logic [P*DW-1:0] exp_frame;
        int t;
        flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
        spur_done = 0; spur_dat = '0;

        // Reset state
        #12;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_stage_start", bus.stage_start, 0);
        check("rst_stage_idx", bus.stage_idx, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        check("rst_frame", bus.frame_q, '0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;

        // Identity frame, no stalls
        out_ready = 1; eng_delay = 0; eng_delta = '0;
        sq.delete(); dbl_start = 0;
        send(32'h0, 8, 0);
        wait_outs(8);
        check("ident_latency", first_out_cyc - last_in_cyc, 7);
        check_frame("ident", 32'h0, 32'h0);
        check_starts("ident");
        check("ident_err", bus.err, 0);
        check("ident_busy_idle", bus.busy, 0);

        // Input gaps plus output stall at sample 3
        out_ready = 0;
        send(32'h0, 8, 1);
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.out_valid && t < 200);
        check("bp_busy_drain", bus.busy, 1);
        @(posedge clk); #1 out_ready = 1;
        repeat (3) @(posedge clk);
        #1 out_ready = 0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check($sformatf("bp_stall_data%0d", s), bus.out_data, 32'h0000_0006);
            check($sformatf("bp_stall_busy%0d", s), bus.busy, 1);
        end
        @(posedge clk); #1 out_ready = 1;
        wait_outs(8);
        check("bp_busy_after", bus.busy, 0);
        check_frame("bp", 32'h0, 32'h0);
        sq.delete(); dbl_start = 0;

        // Slow engine with per-stage increment
        eng_delay = 20; eng_delta = 32'h0001_0001;
        send(32'h0, 8, 0);
        wait_outs(8);
        check_frame("slow", 32'h0, 32'h0003_0003);
        check_starts("slow");

        // Spurious done during LOAD
        eng_delay = 0; eng_delta = '0;
        for (int k = 0; k < P; k++) spur_dat[k*DW +: DW] = 32'hDEAD_BEEF;
        spur_done = 1;
        @(posedge clk); #1 spur_done = 0;
        @(negedge clk);
        check("spur_err", bus.err, 1);
        for (int k = 0; k < P; k++) exp_frame[k*DW +: DW] = DW'(br(k)) + 32'h0003_0003;
        check("spur_frame_kept", bus.frame_q, exp_frame);
        @(posedge clk); #1;
        send(32'h20, 8, 0);
        wait_outs(8);
        check_frame("spur", 32'h20, 32'h0);
        check("spur_err_sticky", bus.err, 1);
        sq.delete();

        // Flush after 5 inputs, with a sixth handshake in the flush cycle
        send(32'h40, 5, 0);
        in_valid = 1; in_data = 32'h45; flush = 1;
        @(posedge clk); #1 flush = 0; in_valid = 0;
        @(negedge clk);
        check("flush_busy", bus.busy, 0);
        check("flush_err_kept", bus.err, 1);
        @(posedge clk); #1;
        send(32'h10, 8, 0);
        wait_outs(8);
        check_frame("flush", 32'h10, 32'h0);
        sq.delete();

        // Asynchronous reset while waiting on the engine
        eng_delay = 20;
        send(32'h50, 8, 0);
        repeat (5) @(posedge clk);
        #2;
        kill_gen++;
        rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_err", bus.err, 0);
        check("arst_in_ready", bus.in_ready, 0);
        check("arst_stage_start", bus.stage_start, 0);
        check("arst_frame", bus.frame_q, '0);
        @(posedge clk); #2 rst_n = 1'b1;
        eng_delay = 0;
        repeat (25) @(posedge clk);
        #1;
        oq.delete(); ol.delete(); sq.delete(); dbl_start = 0;
        send(32'h60, 8, 0);
        wait_outs(8);
        check_frame("arst", 32'h60, 32'h0);
        check_starts("arst");
        check("arst_err_after", bus.err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Frame-level controller for the 8-point FFT datapath.
- Accepts a serial stream of complex samples and writes each one into an internal frame buffer at its bit-reversed address, so the bit-reversal permutation happens at load time.
- Sequences the butterfly engine through log2(points) stages using a start/done handshake, writing each stage result back into the buffer.
- Streams the finished frame out in natural order over a valid/ready interface.

Parameters:
- N, 3, log2 of FFT points; frame holds 2^N samples.
- DW, 32, complex sample width: re in [DW-1:DW/2], im in [DW/2-1:0]. The sequencer never interprets sample data.
- SW, 2, width of stage_idx; must satisfy 2^SW >= N.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; discards the current frame.
- in_valid  in  1  input sample valid.
- in_ready  out  1  sequencer can accept an input sample.
- in_data  in  DW  input sample, natural time order.
- frame_q  out  (2^N)*DW  buffer contents, flat; slot k at bits [k*DW +: DW]. Feeds the butterfly engine.
- stage_start  out  1  one-cycle pulse telling the engine to run stage stage_idx.
- stage_idx  out  SW  current stage, 0..N-1.
- stage_done  in  1  engine result on eng_data is valid this cycle.
- eng_data  in  (2^N)*DW  engine result frame; same slot layout as frame_q.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output sample.
- out_data  out  DW  output sample, natural frequency order.
- out_last  out  1  marks the final sample (index 2^N-1) of a frame.
- busy  out  1  high in RUN, WAIT and DRAIN.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_n=0, asynchronous): state=LOAD; cnt=0; stage_idx=0; every buffer slot=0; in_ready=0 while reset is asserted, then 1 from the first cycle after release; out_valid=0; out_last=0; stage_start=0; busy=0; err=0.
- Reset mid-operation aborts immediately; no partial frame is retained or emitted.
- States: LOAD, RUN, WAIT, DRAIN. cnt is N bits wide.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: buf[bitrev(cnt)] <= in_data; cnt++.
  - Accepting with cnt==2^N-1: next state RUN, stage_idx=0, cnt wraps to 0.
  - bitrev(i) maps i[b] to i[N-1-b]. For N=3 the slot order is 0,4,2,6,1,5,3,7.
- RUN: stage_start=1 for exactly one cycle; next state WAIT.
- WAIT:
  - stage_start=0; waits an unbounded time for stage_done.
  - On stage_done: all slots <= eng_data in one cycle.
  - If stage_idx==N-1: next state DRAIN, cnt=0.
  - Otherwise: stage_idx++, next state RUN.
  - Start-to-start spacing is therefore at least 2 cycles.
- DRAIN:
  - out_valid=1; out_data=buf[cnt]; out_last=(cnt==2^N-1).
  - out_data and out_last are combinational from registered state.
  - On out_valid&out_ready: cnt++.
  - Accepting the last sample: next state LOAD, cnt=0, stage_idx=0.
  - out_data must hold stable while out_valid=1 and out_ready=0.
- Latency: the first output is valid 2N+1 cycles after the final input accept, with the engine asserting done in the cycle right after start.
- The buffer is not cleared between frames; each LOAD overwrites every slot.
- stage_done while not in WAIT: ignored (buffer unchanged) and err<=1. err clears only on reset.
- flush (sync, highest priority after reset): next state LOAD, cnt=0, stage_idx=0, out_valid=0, stage_start=0; err is kept.
  - A same-cycle input or output handshake is discarded and does not count.
  - An engine run in progress is abandoned; a stage_done arriving after flush sets err.
- in_ready=0 outside LOAD, so there is no overlap between frames.

Test Plan:
- Identity frame: engine model returns eng_data=frame_q one cycle after stage_start; input 0x0000_0000..0x0000_0007, no stalls -> exactly 3 stage_start pulses with stage_idx 0,1,2; outputs 0,4,2,6,1,5,3,7; out_last only on the 8th output; first out_valid 7 cycles after the last input accept.
- Backpressure and gaps: random in_valid gaps plus out_ready held low 5 cycles at output 3 -> out_data stays 0x0000_0006 throughout the stall; no sample lost or duplicated; busy=1 from RUN through the final output accept.
- Slow engine: stage_done delayed 20 cycles per stage, with eng_data = frame_q + 0x0001_0001 per slot -> final slot k = bitrev-order input + 0x0003_0003; stage_start remains single-cycle.
- Spurious done: stage_done pulsed during LOAD -> err=1; buffer unchanged; the frame still completes correctly; err stays 1 until rst_n falls.
- Flush: flush asserted after 5 of 8 inputs, then a fresh 8-sample frame 0x10..0x17 -> output is 0x10,0x14,0x12,0x16,0x11,0x15,0x13,0x17.
- Async reset in WAIT: rst_n pulsed low mid-cycle -> outputs take reset values immediately (not on the next edge); the next frame completes normally.
